// File: rtl/count_ud_mod_if.sv
// ---------------------------------------------------------------------------
// count_ud_if
//   Bundles the control, data and status signals of the count_ud_mod
//   up/down counter so that the controller and the counter connect through
//   one port.
//
//   Signals (controller -> counter):
//     en      count enable, one step per enabled cycle
//     load    synchronous load of cnt_in, wins over en
//     cnt_in  load value (clamped to limit by the counter)
//     up      direction: 1 = increment, 0 = decrement
//     limit   top count; count range is 0..limit
//     mode    00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   Signals (counter -> controller):
//     cnt     current count
//     tc      terminal-count pulse, one cycle per boundary step
//     done    one-shot finished flag
//
//   Modports: master = controller side, slave = counter side.
// ---------------------------------------------------------------------------
interface count_ud_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] cnt_in;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             done;

    modport master (
        output en, load, cnt_in, up, limit, mode,
        input  cnt, tc, done
    );

    modport slave (
        input  en, load, cnt_in, up, limit, mode,
        output cnt, tc, done
    );
endinterface

// File: rtl/count_ud_mod.sv
// ---------------------------------------------------------------------------
// count_ud_mod
//   Parametrised up/down counter with synchronous load, count enable,
//   programmable top count (limit) and a selectable end-of-count behaviour:
//   wrap, saturate or one-shot. The count, the terminal-count pulse and the
//   one-shot done flag are all registered.
//
//   Ports:
//     clk  clock, all state updates on the rising edge
//     res  asynchronous reset, active-high
//     bus  count_ud_if.slave (en, load, cnt_in, up, limit, mode in;
//          cnt, tc, done out)
//
//   A two-state FSM (COUNT / HALT) tracks whether a one-shot run has
//   finished; HALT ignores en and is left only through load or reset.
// ---------------------------------------------------------------------------
module count_ud_mod #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       res,
    count_ud_if.slave  bus
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_HALT  = 1'b1
    } state_e;

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_ONE = 2'b10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] load_val;
    logic             at_bound;
    logic             step_en;

    // Shared decode used by both the next-state and the output logic.
    always_comb begin
        load_val = (bus.cnt_in > bus.limit) ? bus.limit : bus.cnt_in;
        // Counting up uses >= so that a limit lowered below the current count
        // is still treated as the boundary instead of running on to 2^WIDTH.
        at_bound = bus.up ? (cnt_q >= bus.limit) : (cnt_q == '0);
        step_en  = (state_q == ST_COUNT) && bus.en;
    end

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ST_COUNT;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ST_COUNT;
        end else if (step_en && at_bound && (bus.mode == MODE_ONE)) begin
            state_d = ST_HALT;
        end
    end

    // ------------------------------------------------------------ output logic
    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (bus.load) begin
            cnt_d  = load_val;
            done_d = 1'b0;
        end else if (step_en) begin
            if (!at_bound) begin
                if (bus.up) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // A count left above a freshly lowered limit is pulled
                    // back into range instead of stepping down from outside.
                    cnt_d = (cnt_q > bus.limit) ? bus.limit : cnt_q - 1'b1;
                end
            end else begin
                tc_d = 1'b1;
                case (bus.mode)
                    MODE_SAT: begin
                        // Holding at the top also clamps a count that sits
                        // above a lowered limit.
                        cnt_d = bus.up ? bus.limit : cnt_q;
                    end
                    MODE_ONE: begin
                        cnt_d  = bus.up ? bus.limit : cnt_q;
                        done_d = 1'b1;
                    end
                    default: begin
                        cnt_d = bus.up ? '0 : bus.limit;
                    end
                endcase
            end
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.tc   = tc_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_count_ud_mod.sv
// ---------------------------------------------------------------------------
// tb_count_ud_mod
//   Directed-vector bench for count_ud_mod. The driver applies one input
//   vector per clock (on the falling edge) and queues the hand-computed
//   {cnt, tc, done} expected after the following rising edge; a monitor
//   pops one entry per rising edge and compares. Reset behaviour is checked
//   directly against the asynchronous reset.
// ---------------------------------------------------------------------------
module tb_count_ud_mod;

    localparam int WIDTH = 8;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] cnt;
        logic             tc;
        logic             done;
    } exp_t;

    logic clk = 1'b0;
    logic res;

    count_ud_if #(.WIDTH(WIDTH)) bus ();

    count_ud_mod #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one vector, queue what must appear after the next rising edge,
    // then move on to the next falling edge.
    task automatic step(input logic e, input logic l, input logic [WIDTH-1:0] ci,
                        input logic [WIDTH-1:0] c, input logic t, input logic d,
                        input string name);
        exp_t x;
        bus.en     = e;
        bus.load   = l;
        bus.cnt_in = ci;
        x.name = name;
        x.cnt  = c;
        x.tc   = t;
        x.done = d;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: the counter presents a new result every cycle.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check(x.name, {22'b0, bus.cnt, bus.tc, bus.done},
                              {22'b0, x.cnt, x.tc, x.done});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        res        = 1'b1;
        bus.en     = 1'b1;
        bus.load   = 1'b0;
        bus.cnt_in = '0;
        bus.up     = 1'b1;
        bus.limit  = 8'd255;
        bus.mode   = 2'b00;

        // 1. Reset held with en=1: state stays cleared, then counts 1,2,3.
        @(negedge clk);
        @(negedge clk);
        check("reset_cnt",  {24'b0, bus.cnt}, 32'd0);
        check("reset_tc",   {31'b0, bus.tc},  32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        res = 1'b0;
        step(1, 0, 0, 8'd1, 0, 0, "t1_cnt1");
        step(1, 0, 0, 8'd2, 0, 0, "t1_cnt2");
        step(1, 0, 0, 8'd3, 0, 0, "t1_cnt3");

        // 2. Wrap up, limit 5.
        bus.limit = 8'd5;
        step(0, 1, 8'd0, 8'd0, 0, 0, "t2_load0");
        step(1, 0, 0, 8'd1, 0, 0, "t2_cnt1");
        step(1, 0, 0, 8'd2, 0, 0, "t2_cnt2");
        step(1, 0, 0, 8'd3, 0, 0, "t2_cnt3");
        step(1, 0, 0, 8'd4, 0, 0, "t2_cnt4");
        step(1, 0, 0, 8'd5, 0, 0, "t2_cnt5");
        step(1, 0, 0, 8'd0, 1, 0, "t2_wrap0_tc");
        step(1, 0, 0, 8'd1, 0, 0, "t2_after_wrap");

        // 3. Wrap down, limit 5, from 1.
        bus.up = 1'b0;
        step(0, 1, 8'd1, 8'd1, 0, 0, "t3_load1");
        step(1, 0, 0, 8'd0, 0, 0, "t3_cnt0");
        step(1, 0, 0, 8'd5, 1, 0, "t3_wrap5_tc");
        step(1, 0, 0, 8'd4, 0, 0, "t3_cnt4");

        // 4. Saturate up, limit 200, from 198.
        bus.up    = 1'b1;
        bus.limit = 8'd200;
        bus.mode  = 2'b01;
        step(0, 1, 8'd198, 8'd198, 0, 0, "t4_load198");
        step(1, 0, 0, 8'd199, 0, 0, "t4_cnt199");
        step(1, 0, 0, 8'd200, 0, 0, "t4_cnt200_first");
        step(1, 0, 0, 8'd200, 1, 0, "t4_sat_tc1");
        step(1, 0, 0, 8'd200, 1, 0, "t4_sat_tc2");
        step(0, 0, 0, 8'd200, 0, 0, "t4_idle_hold");

        // 5. One-shot up, limit 3.
        bus.limit = 8'd3;
        bus.mode  = 2'b10;
        step(0, 1, 8'd0, 8'd0, 0, 0, "t5_load0");
        step(1, 0, 0, 8'd1, 0, 0, "t5_cnt1");
        step(1, 0, 0, 8'd2, 0, 0, "t5_cnt2");
        step(1, 0, 0, 8'd3, 0, 0, "t5_cnt3");
        step(1, 0, 0, 8'd3, 1, 1, "t5_done_tc");
        step(1, 0, 0, 8'd3, 0, 1, "t5_halt_hold1");
        step(1, 0, 0, 8'd3, 0, 1, "t5_halt_hold2");
        step(0, 1, 8'd7, 8'd3, 0, 0, "t5_load7_clamp");
        step(1, 0, 0, 8'd3, 1, 1, "t5_rearm_done");
        step(0, 1, 8'd0, 8'd0, 0, 0, "t5_load_from_halt");

        // limit = 0 under each mode (mode 11 behaves as wrap).
        bus.limit = 8'd0;
        bus.mode  = 2'b11;
        step(1, 0, 0, 8'd0, 1, 0, "lim0_wrap11_tc1");
        step(1, 0, 0, 8'd0, 1, 0, "lim0_wrap11_tc2");
        bus.mode = 2'b01;
        step(1, 0, 0, 8'd0, 1, 0, "lim0_sat_tc");
        bus.mode = 2'b10;
        step(1, 0, 0, 8'd0, 1, 1, "lim0_one_done");
        step(1, 0, 0, 8'd0, 0, 1, "lim0_one_halt");
        step(0, 1, 8'd0, 8'd0, 0, 0, "lim0_reload");

        // Limit lowered below the current count while counting up.
        bus.limit = 8'd20;
        bus.mode  = 2'b00;
        step(0, 1, 8'd15, 8'd15, 0, 0, "lower_load15");
        bus.limit = 8'd10;
        step(1, 0, 0, 8'd0, 1, 0, "lower_wrap_tc");

        // 6. load and en together: load wins, no step.
        bus.limit = 8'd20;
        step(1, 1, 8'd9, 8'd9, 0, 0, "t6_load_over_en");
        step(1, 0, 0, 8'd10, 0, 0, "t6_cnt10");
        step(1, 0, 0, 8'd11, 0, 0, "t6_cnt11");

        // Asynchronous reset mid-count, checked before the next rising edge.
        #2;
        res = 1'b1;
        #1;
        check("async_rst_cnt",  {24'b0, bus.cnt}, 32'd0);
        check("async_rst_tc",   {31'b0, bus.tc},  32'd0);
        check("async_rst_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        step(1, 0, 0, 8'd1, 0, 0, "t6_after_reset");
        bus.en = 1'b0;

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
